// File: rtl/periph_pkg.sv
// periph_pkg: I/O address map and shared types for periph_bridge.
//   IO_PAGE_DEFAULT : default upper address bits (addr[31:12]) selecting I/O space
//   *_ADDR          : full byte addresses of the memory-mapped peripherals
//   rsel_e          : source of the data returned on a load
package periph_pkg;

    localparam logic [19:0] IO_PAGE_DEFAULT = 20'hFFFFF;

    localparam logic [31:0] DIG_ADDR   = 32'hFFFF_F000;
    localparam logic [31:0] TIMER_ADDR = 32'hFFFF_F020;
    localparam logic [31:0] LED_ADDR   = 32'hFFFF_F060;
    localparam logic [31:0] SW_ADDR    = 32'hFFFF_F070;
    localparam logic [31:0] BTN_ADDR   = 32'hFFFF_F078;

    typedef enum logic {
        RSEL_DRAM = 1'b0,
        RSEL_IO   = 1'b1
    } rsel_e;

endpackage

// File: rtl/periph_bridge_btn_debounce.sv
// btn_debounce: single-bit button conditioner.
//   clk, rst : clock, asynchronous active-high reset
//   raw      : bouncy button input, asynchronous to clk
//   deb      : debounced level, changes only after DEBOUNCE_CYCLES
//              consecutive cycles of a stable new synchronised level
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    // Counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            deb     <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop synchroniser
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // stage p1 -> deb: any return to the accepted level restarts the count
            if (sync_p1 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/periph_bridge.sv
// periph_bridge: decodes MEM-stage loads/stores into data RAM or
// memory-mapped I/O (digit tube, LEDs, timer, switches, buttons).
//   clk, rst                   : clock, asynchronous active-high reset
//   cpu_addr/we/re/wdata       : CPU access request
//   cpu_rdata                  : load data, valid the cycle after cpu_re, held otherwise
//   dram_we/addr/wdata/rdata   : data RAM port (1-cycle read latency)
//   sw_in, btn_in              : raw asynchronous board inputs
//   led_data/led_en            : LED sink value and one-cycle write pulse
//   dig_data/dig_en            : digit-tube sink value and one-cycle write pulse
module periph_bridge
    import periph_pkg::*;
#(
    parameter logic [19:0] IO_PAGE         = IO_PAGE_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          SW_W            = 24,
    parameter int          BTN_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cpu_addr,
    input  logic             cpu_we,
    input  logic             cpu_re,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             dram_we,
    output logic [31:0]      dram_addr,
    output logic [31:0]      dram_wdata,
    input  logic [31:0]      dram_rdata,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [BTN_W-1:0] btn_in,
    output logic [31:0]      led_data,
    output logic             led_en,
    output logic [31:0]      dig_data,
    output logic             dig_en
);

    localparam logic [11:0] DIG_OFF   = DIG_ADDR[11:0];
    localparam logic [11:0] TIMER_OFF = TIMER_ADDR[11:0];
    localparam logic [11:0] LED_OFF   = LED_ADDR[11:0];
    localparam logic [11:0] SW_OFF    = SW_ADDR[11:0];
    localparam logic [11:0] BTN_OFF   = BTN_ADDR[11:0];

    logic             is_io;
    logic [11:0]      offset;
    logic             wr_led;
    logic             wr_dig;
    logic             wr_timer;
    logic [31:0]      timer;
    logic [SW_W-1:0]  sw_p0;
    logic [SW_W-1:0]  sw_p1;
    logic [BTN_W-1:0] btn_deb;
    logic [31:0]      io_rd;
    logic             vld_p1;
    rsel_e            sel_p1;
    logic [31:0]      io_p1;
    logic [31:0]      rdata_hold;

    assign is_io      = (cpu_addr[31:12] == IO_PAGE);
    assign offset     = cpu_addr[11:0];
    assign dram_we    = cpu_we & ~is_io;
    assign dram_addr  = cpu_addr;
    assign dram_wdata = cpu_wdata;

    assign wr_led   = cpu_we && is_io && (offset == LED_OFF);
    assign wr_dig   = cpu_we && is_io && (offset == DIG_OFF);
    assign wr_timer = cpu_we && is_io && (offset == TIMER_OFF);

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .raw (btn_in[i]),
            .deb (btn_deb[i])
        );
    end

    // stage p0 -> p1: I/O writes become registered values plus one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_data <= '0;
            led_en   <= 1'b0;
            dig_data <= '0;
            dig_en   <= 1'b0;
            timer    <= '0;
            sw_p0    <= '0;
            sw_p1    <= '0;
        end else begin
            led_en <= wr_led;
            dig_en <= wr_dig;
            if (wr_led) led_data <= cpu_wdata;
            if (wr_dig) dig_data <= cpu_wdata;
            // A store to the timer overrides that cycle's increment.
            timer <= wr_timer ? cpu_wdata : timer + 32'd1;
            sw_p0 <= sw_in;
            sw_p1 <= sw_p0;
        end
    end

    always_comb begin
        io_rd = '0;
        if (is_io) begin
            case (offset)
                TIMER_OFF: io_rd = timer;
                SW_OFF:    io_rd = 32'(sw_p1);
                BTN_OFF:   io_rd = 32'(btn_deb);
                default:   io_rd = '0;
            endcase
        end
    end

    // stage p0 -> p1: capture I/O read data alongside the RAM access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            sel_p1     <= RSEL_DRAM;
            io_p1      <= '0;
            rdata_hold <= '0;
        end else begin
            vld_p1 <= cpu_re;
            if (cpu_re) begin
                sel_p1 <= is_io ? RSEL_IO : RSEL_DRAM;
                io_p1  <= io_rd;
            end
            if (vld_p1) rdata_hold <= cpu_rdata;
        end
    end

    // RAM data only exists in the cycle after the read, so it is muxed in
    // combinationally and remembered in rdata_hold for the idle cycles.
    always_comb begin
        cpu_rdata = rdata_hold;
        if (vld_p1) begin
            cpu_rdata = (sel_p1 == RSEL_DRAM) ? dram_rdata : io_p1;
        end
    end

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: directed stimulus with a queue-based scoreboard for
// periph_bridge. Expected loads and sink pulses are queued with the cycle in
// which they must appear; a negedge monitor pops and compares them.
module tb_periph_bridge;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata = '0;
    logic [23:0] sw_in = '0;
    logic [4:0]  btn_in = '0;
    logic [31:0] led_data;
    logic        led_en;
    logic [31:0] dig_data;
    logic        dig_en;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic re_q;
    exp_t rd_q[$];
    exp_t led_q[$];
    exp_t dig_q[$];
    exp_t e_rd, e_led, e_dig;
    logic [31:0] rd_hold = '0;
    logic [31:0] led_hold = '0;
    logic [31:0] dig_hold = '0;

    periph_bridge #(
        .IO_PAGE        (20'hFFFFF),
        .DEBOUNCE_CYCLES(16),
        .SW_W           (24),
        .BTN_W          (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .dram_we   (dram_we),
        .dram_addr (dram_addr),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw_in     (sw_in),
        .btn_in    (btn_in),
        .led_data  (led_data),
        .led_en    (led_en),
        .dig_data  (dig_data),
        .dig_en    (dig_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) re_q <= 1'b0;
        else     re_q <= cpu_re;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_we    = 1'b1;
        e.cyc     = cyc + 1;
        e.data    = data;
        #1;
        chk("dram_we", {31'b0, dram_we}, {31'b0, addr[31:12] != 20'hFFFFF});
        chk("dram_addr", dram_addr, addr);
        chk("dram_wdata", dram_wdata, data);
        if (addr == A_LED) led_q.push_back(e);
        if (addr == A_DIG) dig_q.push_back(e);
        step();
        cpu_we = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] req);
        exp_t e;
        e.cyc    = cyc + 1;
        e.data   = req;
        rd_q.push_back(e);
        cpu_addr = addr;
        cpu_re   = 1'b1;
        step();
        cpu_re   = 1'b0;
    endtask

    task automatic load_dram(input logic [31:0] addr, input logic [31:0] data);
        load(addr, data);
        dram_rdata = data;
        step();
        dram_rdata = '0;
    endtask

    // Monitor: pops the scoreboard whenever a result or pulse is presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (re_q) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e_rd = rd_q.pop_front();
                    chk("rd_data", cpu_rdata, e_rd.data);
                    chk("rd_cycle", cyc, e_rd.cyc);
                    rd_hold = e_rd.data;
                end
            end else begin
                chk("rd_hold", cpu_rdata, rd_hold);
            end

            if (led_en) begin
                if (led_q.size() == 0) begin
                    chk("led_en_unexpected", 32'd1, 32'd0);
                end else begin
                    e_led = led_q.pop_front();
                    chk("led_data", led_data, e_led.data);
                    chk("led_cycle", cyc, e_led.cyc);
                    led_hold = e_led.data;
                end
            end else begin
                chk("led_hold", led_data, led_hold);
            end

            if (dig_en) begin
                if (dig_q.size() == 0) begin
                    chk("dig_en_unexpected", 32'd1, 32'd0);
                end else begin
                    e_dig = dig_q.pop_front();
                    chk("dig_data", dig_data, e_dig.data);
                    chk("dig_cycle", cyc, e_dig.cyc);
                    dig_hold = e_dig.data;
                end
            end else begin
                chk("dig_hold", dig_data, dig_hold);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_led_data", led_data, 32'h0);
        chk("rst_led_en", {31'b0, led_en}, 32'h0);
        chk("rst_dig_data", dig_data, 32'h0);
        chk("rst_dig_en", {31'b0, dig_en}, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        rst = 1'b0;
        step();

        // LED store: single pulse, DIG untouched, RAM not written
        store(A_LED, 32'h00A5_A5A5);
        repeat (4) step();

        // Back-to-back DIG stores
        store(A_DIG, 32'h0000_0011);
        store(A_DIG, 32'h0000_0022);
        store(A_DIG, 32'h0000_0033);
        repeat (3) step();

        // Timer load then consecutive reads
        store(A_TIMER, 32'h0000_0005);
        load(A_TIMER, 32'h0000_0005);
        load(A_TIMER, 32'h0000_0006);
        load(A_TIMER, 32'h0000_0007);
        // Timer wrap
        store(A_TIMER, 32'hFFFF_FFFE);
        load(A_TIMER, 32'hFFFF_FFFE);
        load(A_TIMER, 32'hFFFF_FFFF);
        load(A_TIMER, 32'h0000_0000);
        load(A_TIMER, 32'h0000_0001);
        repeat (2) step();

        // Switches through the synchroniser
        sw_in = 24'h123456;
        repeat (3) step();
        load(A_SW, 32'h0012_3456);

        // RAM read, held value, unmapped I/O, RAM and unmapped stores
        load_dram(32'h0000_0100, 32'hDEAD_BEEF);
        repeat (3) step();
        load(32'hFFFF_F0F0, 32'h0);
        store(32'hFFFF_F0F0, 32'h5555_5555);
        store(32'h0000_0200, 32'h1234_5678);
        repeat (2) step();

        // Button glitch shorter than the debounce window
        btn_in = 5'b00100;
        repeat (10) step();
        btn_in = 5'b00000;
        repeat (20) step();
        load(A_BTN, 32'h0);
        // Held press: accepted exactly after 16 stable synchronised cycles
        btn_in = 5'b00100;
        repeat (17) step();
        load(A_BTN, 32'h0);
        load(A_BTN, 32'h4);
        repeat (5) step();
        load(A_BTN, 32'h4);
        // Release
        btn_in = 5'b00000;
        repeat (17) step();
        load(A_BTN, 32'h4);
        load(A_BTN, 32'h0);
        repeat (2) step();

        // Reset in the middle of a DIG pulse train
        store(A_DIG, 32'h0000_0044);
        store(A_DIG, 32'h0000_0055);
        cpu_addr  = A_DIG;
        cpu_wdata = 32'h0000_0066;
        cpu_we    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_dig_en", {31'b0, dig_en}, 32'h0);
        chk("midrst_dig_data", dig_data, 32'h0);
        chk("midrst_led_data", led_data, 32'h0);
        chk("midrst_cpu_rdata", cpu_rdata, 32'h0);
        rd_q.delete();
        led_q.delete();
        dig_q.delete();
        rd_hold  = '0;
        led_hold = '0;
        dig_hold = '0;
        cpu_we   = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        // Timer restarted from zero on release of reset
        load(A_TIMER, 32'h0000_0001);
        repeat (4) step();

        chk("rd_queue_empty", rd_q.size(), 32'd0);
        chk("led_queue_empty", led_q.size(), 32'd0);
        chk("dig_queue_empty", dig_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
